// File: rtl/btn_pkg.sv
// Shared types and default constants for the button event arbiter.
package btn_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam int unsigned DEF_N_BTN          = 7;
    localparam int unsigned DEF_TICK_LOG2      = 20;
    localparam int unsigned DEF_STABLE_SAMPLES = 2;
    localparam int unsigned DEF_FIFO_DEPTH     = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             press;
    } btn_event_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-sampled stability counter,
// debounced level and a one-cycle edge strobe on the accepting tick.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic state,
    output logic edge_det
);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

    // Edge fires combinationally on the tick that completes the stability run,
    // so the pending flag and the new level land on the same clock edge.
    always_comb begin
        differ   = (sync != state);
        accept   = tick && differ && ((cnt + 1'b1) == CNT_W'(STABLE_SAMPLES));
        edge_det = accept;
    end

    // Stability counter and debounced level, advanced only on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (tick) begin
            if (accept) begin
                state <= ~state;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced button events, round-robin arbitrated into a small FIFO and
// delivered over valid/ready. Single clock domain.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN          = DEF_N_BTN,
    parameter int unsigned TICK_LOG2      = DEF_TICK_LOG2,
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic             clk_25mhz,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_state,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [2:0]       ev_idx,
    output logic             ev_press,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [TICK_LOG2-1:0] presc;
    logic                 tick;
    logic [N_BTN-1:0]     edge_det;
    logic [N_BTN-1:0]     pend_vld;
    logic [N_BTN-1:0]     pend_dir;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 req_found;
    logic                 gnt_vld;
    logic [N_BTN-1:0]     gnt_onehot;
    logic                 pop;
    logic                 can_push;
    logic                 ovf_set;
    btn_event_t           push_ev;
    btn_event_t           head_ev;
    btn_event_t           fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    // Free-running sample prescaler.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) presc <= '0;
        else        presc <= presc + 1'b1;
    end

    assign tick = &presc;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_ch (
            .clk      (clk_25mhz),
            .rst_n    (rst_n),
            .tick     (tick),
            .btn      (btn[g]),
            .state    (btn_state[g]),
            .edge_det (edge_det[g])
        );
    end

    // Round-robin search from ptr; one grant per cycle when the FIFO can take it.
    always_comb begin
        int unsigned pos;
        pos       = 0;
        pop       = ev_valid && ev_ready;
        can_push  = (count < (AW+1)'(FIFO_DEPTH)) || pop;
        req_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N_BTN) pos = pos - N_BTN;
            if (!req_found && pend_vld[pos[IDX_W-1:0]]) begin
                req_found = 1'b1;
                gnt_idx   = pos[IDX_W-1:0];
            end
        end
        gnt_vld = req_found && can_push;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            gnt_onehot[i] = gnt_vld && (gnt_idx == IDX_W'(i));
        end
        push_ev.idx   = gnt_idx;
        push_ev.press = pend_dir[gnt_idx];
        ovf_set       = |(edge_det & pend_vld & ~gnt_onehot);
    end

    // Pending slots, arbiter pointer and sticky overflow (set beats clear).
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= '0;
            pend_dir <= '0;
            ptr      <= '0;
            overflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (edge_det[i]) begin
                    pend_vld[i] <= 1'b1;
                    pend_dir[i] <= ~btn_state[i];
                end else if (gnt_onehot[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
            if (gnt_vld) begin
                ptr <= (gnt_idx == IDX_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (ovf_set)           overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset since ev_valid gates the head.
    always_ff @(posedge clk_25mhz) begin
        if (gnt_vld) fifo_mem[wr_ptr] <= push_ev;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (gnt_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({gnt_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head outputs forced to zero while empty.
    always_comb begin
        head_ev  = fifo_mem[rd_ptr];
        ev_valid = (count != '0);
        ev_idx   = ev_valid ? head_ev.idx : '0;
        ev_press = ev_valid && head_ev.press;
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with a fast prescaler (tick every 16 clocks).
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] btn = '0;
    logic [6:0] btn_state;
    logic       ev_valid;
    logic       ev_ready = 1'b1;
    logic [2:0] ev_idx;
    logic       ev_press;
    logic       overflow;
    logic       clr_overflow = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Delivered events as {idx, press}.
    logic [3:0] evq [$];

    btn_event_arbiter #(
        .N_BTN          (7),
        .TICK_LOG2      (4),
        .STABLE_SAMPLES (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_25mhz    (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .btn_state    (btn_state),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_idx       (ev_idx),
        .ev_press     (ev_press),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Record each handshake mid-cycle; it completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) evq.push_back({ev_idx, ev_press});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %0h want 0", ev_valid); end
        n_cmp++; if (btn_state !== 7'h00) begin n_fail++; $display("FAIL reset_btn_state: got %0h want 0", btn_state); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
        n_cmp++; if ({ev_idx, ev_press} !== 4'h0) begin n_fail++; $display("FAIL reset_head: got %0h want 0", {ev_idx, ev_press}); end
        step(2);
        rst_n = 1'b1;
    endtask

    // Press and release btn[1]; the second tick after release of reset is at clock 32.
    task automatic test_hold_press_release();
        logic [3:0] got;
        btn = 7'h02;
        evq.delete();
        step(31);
        n_cmp++; if (btn_state !== 7'h00) begin n_fail++; $display("FAIL t1_state_before_tick2: got %0h want 0", btn_state); end
        step(1);
        n_cmp++; if (btn_state !== 7'h02) begin n_fail++; $display("FAIL t1_state_at_tick2: got %0h want 2", btn_state); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_T1: got %0h want 0", ev_valid); end
        step(1);
        n_cmp++; if ({ev_valid, ev_idx, ev_press} !== 5'b1_001_1) begin n_fail++; $display("FAIL t1_head_T2: got %0h want %0h", {ev_valid, ev_idx, ev_press}, 5'b1_001_1); end
        step(60);
        got = (evq.size() > 0) ? evq[0] : 4'hx;
        n_cmp++; if (evq.size() != 1 || got !== 4'b001_1) begin n_fail++; $display("FAIL t1_press_events: got n=%0d first=%0h want n=1 first=3", evq.size(), got); end
        evq.delete();
        btn = 7'h00;
        step(60);
        got = (evq.size() > 0) ? evq[0] : 4'hx;
        n_cmp++; if (evq.size() != 1 || got !== 4'b001_0) begin n_fail++; $display("FAIL t1_release_events: got n=%0d first=%0h want n=1 first=2", evq.size(), got); end
        n_cmp++; if (btn_state !== 7'h00) begin n_fail++; $display("FAIL t1_state_released: got %0h want 0", btn_state); end
    endtask

    // Short glitches on btn[4]: never accepted.
    task automatic test_bounce();
        evq.delete();
        btn = 7'h10; step(10); btn = 7'h00; step(40);
        btn = 7'h10; step(16); btn = 7'h00; step(40);
        btn = 7'h10; step(16); btn = 7'h00; step(40);
        n_cmp++; if (btn_state !== 7'h00) begin n_fail++; $display("FAIL t2_state: got %0h want 0", btn_state); end
        n_cmp++; if (evq.size() != 0) begin n_fail++; $display("FAIL t2_no_events: got %0d want 0", evq.size()); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t2_overflow: got %0h want 0", overflow); end
    endtask

    // Simultaneous presses granted 0,3,5; ptr then sits at 6 so release order is 0,5.
    task automatic test_rr_order();
        logic [3:0] exp_a [3];
        logic [3:0] exp_b [2];
        logic [3:0] got;
        exp_a = '{4'b000_1, 4'b011_1, 4'b101_1};
        exp_b = '{4'b000_0, 4'b101_0};
        apply_reset();
        btn = 7'h29;
        evq.delete();
        step(60);
        n_cmp++; if (evq.size() != 3) begin n_fail++; $display("FAIL t3_press_count: got %0d want 3", evq.size()); end
        for (int k = 0; k < 3; k++) begin
            got = (k < evq.size()) ? evq[k] : 4'hx;
            n_cmp++; if (got !== exp_a[k]) begin n_fail++; $display("FAIL t3_press_order[%0d]: got %0h want %0h", k, got, exp_a[k]); end
        end
        evq.delete();
        btn = 7'h08;
        step(60);
        n_cmp++; if (evq.size() != 2) begin n_fail++; $display("FAIL t3_release_count: got %0d want 2", evq.size()); end
        for (int k = 0; k < 2; k++) begin
            got = (k < evq.size()) ? evq[k] : 4'hx;
            n_cmp++; if (got !== exp_b[k]) begin n_fail++; $display("FAIL t3_release_order[%0d]: got %0h want %0h", k, got, exp_b[k]); end
        end
        n_cmp++; if (btn_state !== 7'h08) begin n_fail++; $display("FAIL t3_state: got %0h want 8", btn_state); end
    endtask

    // Full FIFO with btn[4] pending; releasing btn[4] overwrites the pending press.
    task automatic test_overflow();
        logic [3:0] exp_e [5];
        logic [3:0] got;
        exp_e = '{4'b000_1, 4'b001_1, 4'b010_1, 4'b011_1, 4'b100_0};
        btn = 7'h00;
        apply_reset();
        ev_ready = 1'b0;
        btn = 7'h1F;
        evq.delete();
        step(60);
        n_cmp++; if ({ev_valid, ev_idx, ev_press} !== 5'b1_000_1) begin n_fail++; $display("FAIL t4_head_full: got %0h want %0h", {ev_valid, ev_idx, ev_press}, 5'b1_000_1); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t4_no_overflow_yet: got %0h want 0", overflow); end
        btn = 7'h0F;
        step(60);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t4_overflow_set: got %0h want 1", overflow); end
        ev_ready = 1'b1;
        step(20);
        n_cmp++; if (evq.size() != 5) begin n_fail++; $display("FAIL t4_count: got %0d want 5", evq.size()); end
        for (int k = 0; k < 5; k++) begin
            got = (k < evq.size()) ? evq[k] : 4'hx;
            n_cmp++; if (got !== exp_e[k]) begin n_fail++; $display("FAIL t4_order[%0d]: got %0h want %0h", k, got, exp_e[k]); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t4_overflow_sticky: got %0h want 1", overflow); end
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t4_overflow_clear: got %0h want 0", overflow); end
    endtask

    // Single-cycle pop on a full FIFO with a request pending: head advances, nothing lost.
    task automatic test_full_pop_push();
        logic [2:0] exp_i [3];
        exp_i = '{3'd2, 3'd3, 3'd4};
        btn = 7'h00;
        apply_reset();
        ev_ready = 1'b0;
        btn = 7'h1F;
        step(60);
        n_cmp++; if (ev_idx !== 3'd0) begin n_fail++; $display("FAIL t5_head_before: got %0h want 0", ev_idx); end
        evq.delete();
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        n_cmp++; if ({ev_valid, ev_idx, ev_press} !== 5'b1_001_1) begin n_fail++; $display("FAIL t5_head_after_pop: got %0h want %0h", {ev_valid, ev_idx, ev_press}, 5'b1_001_1); end
        step(10);
        n_cmp++; if (ev_idx !== 3'd1) begin n_fail++; $display("FAIL t5_head_stable: got %0h want 1", ev_idx); end
        for (int k = 0; k < 3; k++) begin
            ev_ready = 1'b1;
            step(1);
            ev_ready = 1'b0;
            n_cmp++; if ({ev_valid, ev_idx, ev_press} !== {1'b1, exp_i[k], 1'b1}) begin n_fail++; $display("FAIL t5_drain[%0d]: got %0h want %0h", k, {ev_valid, ev_idx, ev_press}, {1'b1, exp_i[k], 1'b1}); end
        end
        ev_ready = 1'b1;
        step(1);
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL t5_empty: got %0h want 0", ev_valid); end
        n_cmp++; if (evq.size() != 5) begin n_fail++; $display("FAIL t5_total: got %0d want 5", evq.size()); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t5_overflow: got %0h want 0", overflow); end
    endtask

    // Mid-cycle async reset with 3 queued events and overflow set; btn[2] held through.
    task automatic test_async_reset();
        logic [3:0] got;
        btn = 7'h00;
        apply_reset();
        ev_ready = 1'b0;
        btn = 7'h1F;
        step(60);
        btn = 7'h0F;
        step(60);
        ev_ready = 1'b1;
        step(2);
        ev_ready = 1'b0;
        n_cmp++; if ({ev_valid, overflow, btn_state} !== {2'b11, 7'h0F}) begin n_fail++; $display("FAIL t6_pre_reset: got %0h want %0h", {ev_valid, overflow, btn_state}, {2'b11, 7'h0F}); end
        #3;
        rst_n = 1'b0;
        btn = 7'h04;
        #1;
        n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL t6_async_valid: got %0h want 0", ev_valid); end
        n_cmp++; if (btn_state !== 7'h00) begin n_fail++; $display("FAIL t6_async_state: got %0h want 0", btn_state); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t6_async_overflow: got %0h want 0", overflow); end
        step(2);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        evq.delete();
        step(31);
        n_cmp++; if (btn_state !== 7'h00) begin n_fail++; $display("FAIL t6_state_before_tick2: got %0h want 0", btn_state); end
        step(1);
        n_cmp++; if (btn_state !== 7'h04) begin n_fail++; $display("FAIL t6_state_at_tick2: got %0h want 4", btn_state); end
        step(60);
        got = (evq.size() > 0) ? evq[0] : 4'hx;
        n_cmp++; if (evq.size() != 1 || got !== 4'b010_1) begin n_fail++; $display("FAIL t6_events: got n=%0d first=%0h want n=1 first=5", evq.size(), got); end
    endtask

    initial begin
        test_reset();
        test_hold_press_release();
        test_bounce();
        test_rr_order();
        test_overflow();
        test_full_pop_push();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Debounces up to N_BTN board buttons using one shared sample prescaler and a per-button stability counter.
- Turns debounced press/release edges into events and arbitrates them round-robin into a small FIFO.
- Hands events to a consumer (LED/menu logic, counters) over a valid/ready interface.
- Replaces ad-hoc per-button edge logic clocked from divided clocks; everything runs on the single system clock.

Parameters:
N_BTN, 7, number of button inputs (1..8)
TICK_LOG2, 20, sample tick every 2**TICK_LOG2 clocks (~42 ms at 25 MHz)
STABLE_SAMPLES, 2, consecutive differing samples needed to accept a new level (1..15)
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)

Ports:
clk_25mhz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn  in  N_BTN  raw asynchronous button inputs, active-high
btn_state  out  N_BTN  debounced level per button
ev_valid  out  1  event available at head of FIFO
ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
ev_idx  out  3  button index of head event
ev_press  out  1  1 = press (0->1), 0 = release (1->0)
overflow  out  1  sticky: an undelivered pending event was overwritten
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst_n low) clears everything immediately:
  - synchronisers, prescaler, stability counters, btn_state, pending flags and arbiter pointer go to 0;
  - FIFO is emptied; ev_valid=0, ev_idx=0, ev_press=0, overflow=0.
- Release of reset is synchronous. A button held through reset produces a press event after normal debounce.
- Synchroniser: 2-FF on each btn bit. Only synchronised values are used downstream.
- Prescaler: TICK_LOG2-bit free-running counter. tick is a 1-cycle pulse when the counter equals all-ones; wraps to 0.
- Per-button debounce, evaluated only on tick cycles:
  - if sync != btn_state: cnt++;
  - when cnt+1 == STABLE_SAMPLES, btn_state flips, cnt clears and an edge fires;
  - if sync == btn_state: cnt clears.
  - A bounce shorter than STABLE_SAMPLES ticks produces no edge.
- Pending register per button: pend_vld[i], pend_dir[i]. An edge sets pend_vld=1 and pend_dir=new level.
- Edge arriving while pend_vld[i]=1 and not granted that cycle:
  - overwrite pend_dir;
  - set overflow.
- Edge arriving in the same cycle pend_vld[i] is granted: the old event goes to the FIFO, the new one becomes pending, no overflow.
- Arbiter, round-robin:
  - search starts at ptr, wrapping modulo N_BTN; at most one grant per cycle;
  - grant allowed when FIFO count < FIFO_DEPTH, or FIFO full and a pop occurs this cycle;
  - granted entry {i, pend_dir[i]} is written to the FIFO and pend_vld[i] clears;
  - ptr <= (i+1) mod N_BTN; ptr holds when there is no grant.
- FIFO: ev_valid = count != 0. Head fields (ev_idx, ev_press) stay stable while ev_valid & !ev_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push into an empty FIFO sets ev_valid the next cycle (no bypass).
- Latency from the tick cycle T that completes debounce:
  - btn_state and pend_vld visible at T+1;
  - grant at T+1;
  - ev_valid at T+2 if the FIFO was empty and no other pending request held priority.
- overflow clears on clr_overflow unless a new overwrite occurs in the same cycle; set wins.
- Unused ev_idx bits are driven to 0 for N_BTN < 8.

Decomposition:
- Package btn_pkg:
  - IDX_W = 3;
  - typedef btn_event_t {logic [IDX_W-1:0] idx; logic press;};
  - default parameter constants.
- Sub-module btn_debounce_ch: one button's synchroniser, stability counter, btn_state and edge pulse. It takes tick as an input and is instantiated N_BTN times.
- Prescaler, pending logic, arbiter and FIFO live in the top block.

Test Plan:
All scenarios use TICK_LOG2=4 (tick every 16 cycles), STABLE_SAMPLES=2, N_BTN=7, FIFO_DEPTH=4, ev_ready=1 unless stated.
1. Hold btn[1]=1: btn_state[1]=1 after the second tick; exactly one event {idx=1, press=1}. Drop btn[1] → one event {1, 0}.
2. Pulse btn[4] high for 10 cycles between ticks, then repeatedly for only 1 tick → btn_state stays 0; no event; overflow=0.
3. Raise btn[0], btn[3], btn[5] in the same cycle → events in order 0, 3, 5 on consecutive grants (ptr=6 after). Next simultaneous release of 5 and 0 → order 0, 5.
4. ev_ready=0; five buttons pressed together → 4 events queued, fifth pending; overflow=0. Release that fifth button before raising ev_ready → overflow=1. With ev_ready=1, the remaining event for that button is the release.
5. FIFO full; ev_ready=1 for one cycle with a pending request → simultaneous pop and push; count stays 4; ev_idx advances to the second entry.
6. 3 events queued; pulse rst_n low mid-cycle → ev_valid, btn_state and overflow are 0 before the next clock edge. After release with btn[2] still held → one {2, 1} event after 2 ticks.
